// File: rtl/accel_run_sequencer.sv
// accel_run_sequencer: board-level run controller for the generated accelerator.
// A rising edge on go launches the accelerator run_count times back-to-back.
// Each run is timed in clock cycles, and the controller keeps the last return
// value plus last/max/total cycle statistics for the HEX/LED display.
// Optional watchdog: define ACCEL_TIMEOUT_EN to abort a run that exceeds
// TIMEOUT cycles in EXE and park in ERR. Without it, ERR is unreachable and
// timeout is tied low.
module accel_run_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int RUNS_W  = 8,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [RUNS_W-1:0] run_count,
    output logic              start,
    input  logic              finish,
    input  logic [DATA_W-1:0] return_val,
    output logic [2:0]        state,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [RUNS_W-1:0] runs_done,
    output logic [DATA_W-1:0] last_val,
    output logic [CNT_W-1:0]  last_cycles,
    output logic [CNT_W-1:0]  max_cycles,
    output logic [CNT_W-1:0]  total_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_EXE   = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

`ifdef ACCEL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
`endif

    state_t             state_q, state_d;
    logic               go_q, go_d;
    logic [RUNS_W-1:0]  count_q, count_d;
    logic [RUNS_W-1:0]  runs_done_q, runs_done_d;
    logic [DATA_W-1:0]  last_val_q, last_val_d;
    logic [CNT_W-1:0]   last_cycles_q, last_cycles_d;
    logic [CNT_W-1:0]   max_cycles_q, max_cycles_d;
    logic [CNT_W-1:0]   total_cycles_q, total_cycles_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               go_rise;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W:0]     total_sum;
    logic [CNT_W-1:0]   total_add;
    logic [RUNS_W-1:0]  runs_next;

    // Edge detect, saturating cycle count of the run in progress, saturating total
    always_comb begin
        go_rise   = go & ~go_q;
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        total_sum = {1'b0, total_cycles_q} + {1'b0, cnt_inc};
        total_add = total_sum[CNT_W] ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
        runs_next = runs_done_q + RUNS_W'(1);
    end

    // Next-state and statistics update; cnt_inc is the cycle count including this cycle
    always_comb begin
        state_d        = state_q;
        go_d           = go;
        count_d        = count_q;
        runs_done_d    = runs_done_q;
        last_val_d     = last_val_q;
        last_cycles_d  = last_cycles_q;
        max_cycles_d   = max_cycles_q;
        total_cycles_d = total_cycles_q;
        cnt_d          = cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A zero run count is not a launch: leave state and stats alone
                if (go_rise && (run_count != '0)) begin
                    state_d        = S_START;
                    count_d        = run_count;
                    runs_done_d    = '0;
                    last_val_d     = '0;
                    last_cycles_d  = '0;
                    max_cycles_d   = '0;
                    total_cycles_d = '0;
                    cnt_d          = '0;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_EXE;
            end
            S_EXE: begin
                cnt_d = cnt_inc;
                if (finish) begin
                    last_cycles_d  = cnt_inc;
                    last_val_d     = return_val;
                    total_cycles_d = total_add;
                    if (cnt_inc > max_cycles_q) begin
                        max_cycles_d = cnt_inc;
                    end
                    runs_done_d = runs_next;
                    state_d     = (runs_next == count_q) ? S_DONE : S_GAP;
                end
`ifdef ACCEL_TIMEOUT_EN
                // Finish on the limit cycle still counts as a completed run
                else if (cnt_inc >= TIMEOUT_CNT) begin
                    last_cycles_d = TIMEOUT_CNT;
                    state_d       = S_ERR;
                end
`endif
            end
            S_GAP: begin
                // Accelerator may hold finish for several cycles; wait for it to drop
                if (!finish) begin
                    state_d = S_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and statistics registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            go_q           <= 1'b0;
            count_q        <= '0;
            runs_done_q    <= '0;
            last_val_q     <= '0;
            last_cycles_q  <= '0;
            max_cycles_q   <= '0;
            total_cycles_q <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            go_q           <= go_d;
            count_q        <= count_d;
            runs_done_q    <= runs_done_d;
            last_val_q     <= last_val_d;
            last_cycles_q  <= last_cycles_d;
            max_cycles_q   <= max_cycles_d;
            total_cycles_q <= total_cycles_d;
            cnt_q          <= cnt_d;
        end
    end

    // Status outputs decode straight from the state register so reset drops them at once
    assign state        = state_q;
    assign start        = (state_q == S_START);
    assign busy         = (state_q == S_START) || (state_q == S_EXE) || (state_q == S_GAP);
    assign done         = (state_q == S_DONE);
`ifdef ACCEL_TIMEOUT_EN
    assign timeout      = (state_q == S_ERR);
`else
    assign timeout      = 1'b0;
`endif
    assign runs_done    = runs_done_q;
    assign last_val     = last_val_q;
    assign last_cycles  = last_cycles_q;
    assign max_cycles   = max_cycles_q;
    assign total_cycles = total_cycles_q;

endmodule

// File: tb/tb_accel_run_sequencer.sv
// Bench for accel_run_sequencer: a 32-bit-counter instance and an 8-bit-counter
// instance share the same stimulus; a per-launch model of run lengths predicts stats.
module tb_accel_run_sequencer;

    localparam int TOUT = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        finish = 1'b0;
    logic [7:0]  run_count = 8'd0;
    logic [31:0] return_val = 32'd0;

    logic        b_start, b_busy, b_done, b_timeout;
    logic [2:0]  b_state;
    logic [7:0]  b_runs_done;
    logic [31:0] b_last_val, b_last_cycles, b_max_cycles, b_total_cycles;

    logic        s_start, s_busy, s_done, s_timeout;
    logic [2:0]  s_state;
    logic [7:0]  s_runs_done;
    logic [31:0] s_last_val;
    logic [7:0]  s_last_cycles, s_max_cycles, s_total_cycles;

    accel_run_sequencer #(.DATA_W(32), .CNT_W(32), .RUNS_W(8), .TIMEOUT(TOUT)) dut_big (
        .clk(clk), .reset(reset), .go(go), .run_count(run_count), .start(b_start),
        .finish(finish), .return_val(return_val), .state(b_state), .busy(b_busy),
        .done(b_done), .timeout(b_timeout), .runs_done(b_runs_done), .last_val(b_last_val),
        .last_cycles(b_last_cycles), .max_cycles(b_max_cycles), .total_cycles(b_total_cycles)
    );

    accel_run_sequencer #(.DATA_W(32), .CNT_W(8), .RUNS_W(8), .TIMEOUT(TOUT)) dut_small (
        .clk(clk), .reset(reset), .go(go), .run_count(run_count), .start(s_start),
        .finish(finish), .return_val(return_val), .state(s_state), .busy(s_busy),
        .done(s_done), .timeout(s_timeout), .runs_done(s_runs_done), .last_val(s_last_val),
        .last_cycles(s_last_cycles), .max_cycles(s_max_cycles), .total_cycles(s_total_cycles)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int b_starts = 0;
    int s_starts = 0;

    // Count start cycles away from the active edge
    always @(negedge clk) begin
        if (b_start) b_starts++;
        if (s_start) s_starts++;
    end

    // Reference model: statistics derived from the list of run lengths of this launch
    longint      m_tot_b, m_tot_s, m_max_b, m_max_s, m_last_b, m_last_s;
    int          m_runs;
    logic [31:0] m_val;

    function automatic longint satl(input longint x, input longint lim);
        return (x > lim) ? lim : x;
    endfunction

    task automatic model_clear();
        m_tot_b = 0; m_tot_s = 0; m_max_b = 0; m_max_s = 0;
        m_last_b = 0; m_last_s = 0; m_runs = 0; m_val = 32'd0;
    endtask

    task automatic model_run(input int len, input logic [31:0] val);
        longint cb, cs;
        cb = satl(len, 64'hFFFF_FFFF);
        cs = satl(len, 255);
        m_last_b = cb;
        m_last_s = cs;
        m_tot_b  = satl(m_tot_b + cb, 64'hFFFF_FFFF);
        m_tot_s  = satl(m_tot_s + cs, 255);
        if (cb > m_max_b) m_max_b = cb;
        if (cs > m_max_s) m_max_s = cs;
        m_runs++;
        m_val = val;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats();
        check("b_runs_done", 64'(b_runs_done), 64'(m_runs));
        check("b_last_val", 64'(b_last_val), 64'(m_val));
        check("b_last_cycles", 64'(b_last_cycles), m_last_b);
        check("b_max_cycles", 64'(b_max_cycles), m_max_b);
        check("b_total_cycles", 64'(b_total_cycles), m_tot_b);
        check("s_runs_done", 64'(s_runs_done), 64'(m_runs));
        check("s_last_val", 64'(s_last_val), 64'(m_val));
        check("s_last_cycles", 64'(s_last_cycles), m_last_s);
        check("s_max_cycles", 64'(s_max_cycles), m_max_s);
        check("s_total_cycles", 64'(s_total_cycles), m_tot_s);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, 64'(b_state), 64'd1);
        check({tag, "_start"}, 64'(b_start), 64'd0);
        check({tag, "_busy"}, 64'(b_busy), 64'd0);
        check({tag, "_done"}, 64'(b_done), 64'd0);
        check({tag, "_timeout"}, 64'(b_timeout), 64'd0);
        check({tag, "_s_state"}, 64'(s_state), 64'd1);
        check({tag, "_s_start"}, 64'(s_start), 64'd0);
        model_clear();
        check_stats();
    endtask

    // Assert reset between clock edges and check everything clears without an edge
    task automatic do_reset_mid();
        #2;
        reset = 1'b1;
        go = 1'b0;
        finish = 1'b0;
        #1;
        check_cleared("async_reset");
        #3;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (b_start) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic launch(input int n, input int lens[8], input int holds[8],
                          input bit keep_go, input bit poke, input int abort_run);
        int st_b, st_s, len;
        bit ok;
        go = 1'b0;
        @(posedge clk); #1;
        st_b = b_starts;
        st_s = s_starts;
        go = 1'b1;
        run_count = 8'(n);
        model_clear();
        @(posedge clk); #1;
        if (!keep_go) go = 1'b0;
        for (int r = 0; r < n; r++) begin
            wait_start(ok);
            check("start_seen", 64'(ok), 64'd1);
            if (!ok) return;
            @(posedge clk); #1;
            check("start_one_cycle", 64'(b_start), 64'd0);
            check("exe_state", 64'(b_state), 64'd3);
            check("exe_busy", 64'(b_busy), 64'd1);
            if (r == abort_run) begin
                repeat (2) begin @(posedge clk); #1; end
                do_reset_mid();
                return;
            end
            len = lens[r];
            if (poke && !keep_go && r == 0 && len >= 2) begin
                // go pulse and run_count change mid-run must be ignored
                go = 1'b1;
                run_count = 8'd200;
                @(posedge clk); #1;
                go = 1'b0;
                repeat (len - 2) begin @(posedge clk); #1; end
            end else begin
                repeat (len - 1) begin @(posedge clk); #1; end
            end
            finish = 1'b1;
            return_val = $urandom;
            @(posedge clk); #1;
            model_run(len, return_val);
            check_stats();
            if (r < n - 1) begin
                check("gap_state", 64'(b_state), 64'd4);
                check("s_gap_state", 64'(s_state), 64'd4);
            end else begin
                check("done_state", 64'(b_state), 64'd5);
                check("done_flag", 64'(b_done), 64'd1);
                check("done_busy", 64'(b_busy), 64'd0);
                check("s_done_state", 64'(s_state), 64'd5);
            end
            repeat (holds[r] - 1) begin @(posedge clk); #1; end
            finish = 1'b0;
        end
        check("start_pulses", 64'(b_starts - st_b), 64'(n));
        check("s_start_pulses", 64'(s_starts - st_s), 64'(n));
        $display("launch runs=%0d total=%0d max=%0d last=%0d", n, b_total_cycles, b_max_cycles, b_last_cycles);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int lens[8];
        int holds[8];
        int n, st_b;

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single run of 7 cycles
        lens = '{7, 1, 1, 1, 1, 1, 1, 1};
        holds = '{1, 1, 1, 1, 1, 1, 1, 1};
        launch(1, lens, holds, 1'b0, 1'b0, -1);

        // Three runs, finish held two cycles each
        lens = '{4, 9, 5, 1, 1, 1, 1, 1};
        holds = '{2, 2, 2, 1, 1, 1, 1, 1};
        launch(3, lens, holds, 1'b0, 1'b0, -1);

        // go held through DONE must not relaunch
        lens = '{3, 6, 1, 1, 1, 1, 1, 1};
        holds = '{1, 3, 1, 1, 1, 1, 1, 1};
        launch(2, lens, holds, 1'b1, 1'b0, -1);
        st_b = b_starts;
        repeat (5) begin @(posedge clk); #1; end
        check("held_go_state", 64'(b_state), 64'd5);
        check("held_go_no_start", 64'(b_starts - st_b), 64'd0);
        check_stats();

        // Rise with run_count zero is ignored
        go = 1'b0;
        @(posedge clk); #1;
        go = 1'b1;
        run_count = 8'd0;
        repeat (3) begin @(posedge clk); #1; end
        check("zero_count_state", 64'(b_state), 64'd5);
        check("zero_count_no_start", 64'(b_starts - st_b), 64'd0);
        check_stats();
        go = 1'b0;

        // go pulse during EXE ignored
        lens = '{6, 2, 3, 1, 1, 1, 1, 1};
        holds = '{1, 1, 2, 1, 1, 1, 1, 1};
        launch(3, lens, holds, 1'b0, 1'b1, -1);

        // Async reset during the second run's EXE
        lens = '{5, 8, 1, 1, 1, 1, 1, 1};
        holds = '{1, 1, 1, 1, 1, 1, 1, 1};
        launch(2, lens, holds, 1'b0, 1'b0, 1);

        // Run that never finishes
        go = 1'b1;
        run_count = 8'd1;
        @(posedge clk); #1;
        go = 1'b0;
        check("to_start", 64'(b_start), 64'd1);
        @(posedge clk); #1;
        repeat (TOUT - 1) begin @(posedge clk); #1; end
        check("to_before_limit", 64'(b_state), 64'd3);
        @(posedge clk); #1;
`ifdef ACCEL_TIMEOUT_EN
        check("to_err_state", 64'(b_state), 64'd6);
        check("to_flag", 64'(b_timeout), 64'd1);
        check("to_last_cycles", 64'(b_last_cycles), 64'd100);
        check("to_runs_done", 64'(b_runs_done), 64'd0);
        check("s_to_err_state", 64'(s_state), 64'd6);
        check("s_to_last_cycles", 64'(s_last_cycles), 64'd100);
        lens = '{3, 1, 1, 1, 1, 1, 1, 1};
        holds = '{1, 1, 1, 1, 1, 1, 1, 1};
        launch(1, lens, holds, 1'b0, 1'b0, -1);
`else
        repeat (50) begin @(posedge clk); #1; end
        check("no_to_state", 64'(b_state), 64'd3);
        check("no_to_flag", 64'(b_timeout), 64'd0);
        check("s_no_to_state", 64'(s_state), 64'd3);
        do_reset_mid();
`endif

        // Long runs: 8-bit total saturates at 255
        lens = '{200, 200, 200, 1, 1, 1, 1, 1};
        holds = '{1, 1, 1, 1, 1, 1, 1, 1};
        launch(3, lens, holds, 1'b0, 1'b0, -1);
        check("sat_total_small", 64'(s_total_cycles), 64'd255);
        check("sat_total_big", 64'(b_total_cycles), 64'd600);

        // Randomized launches, including occasional runs past the 8-bit limit
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++) begin
                lens[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 12);
                holds[i] = $urandom_range(1, 3);
            end
            launch(n, lens, holds, 1'(($urandom_range(0, 3)) == 0), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
